// File: rtl/blockram_pkg.sv
// Shared encodings for the blockram arbiter: access sizes, response owner and bytes per word.
package blockram_pkg;

  localparam int unsigned BYTES = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane handling: store byte enables and lane replication, misalignment detection,
// and load lane extraction with sign/zero extension.
module lsu_align
  import blockram_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        st_err_o,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_err_o   = 1'b0;
    st_be_o    = 4'b0000;
    st_wdata_o = 32'h0;
    unique case (st_size_i)
      SZ_BYTE: begin
        st_be_o    = 4'b0001 << st_addr_i;
        st_wdata_o = {BYTES{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_err_o   = st_addr_i[0];
        st_be_o    = 4'b0011 << st_addr_i;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      SZ_WORD: begin
        st_err_o   = (st_addr_i != 2'b00);
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
      end
      default: st_err_o = 1'b1;
    endcase
    // Erroneous accesses must never touch the RAM.
    if (st_err_o) begin
      st_be_o = 4'b0000;
    end
  end

  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_addr_i, 3'b000};
    ld_data_o  = 32'h0;
    unique case (ld_size_i)
      SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_shifted[7:0]}
                                         : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_shifted[15:0]}
                                         : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_WORD: ld_data_o = ld_shifted;
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/blockram_arbiter.sv
// Shares one single-port byte-enabled blockram between instruction fetch (I) and load/store (D),
// with a bounded D streak so a pending fetch cannot starve.
module blockram_arbiter
  import blockram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_D_STREAK  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_req_i,
  input  logic [ADDRESS_WIDTH-1:0] i_addr_i,
  output logic                     i_gnt_o,
  output logic                     i_rvalid_o,
  output logic [DATA_WIDTH-1:0]    i_rdata_o,
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [1:0]               d_size_i,
  input  logic                     d_unsigned_i,
  input  logic [ADDRESS_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0]    d_wdata_i,
  output logic                     d_gnt_o,
  output logic                     d_rvalid_o,
  output logic [DATA_WIDTH-1:0]    d_rdata_o,
  output logic                     d_err_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [3:0]               mem_be_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  output logic                     mem_we_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

  localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

  logic [3:0]            streak_q, streak_d;
  owner_e                owner_q, owner_d;
  logic [1:0]            size_q, addr_q;
  logic                  unsigned_q, we_q, err_q;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata, ld_data;
  logic                  st_err;

  lsu_align u_lsu_align (
    .st_size_i     (d_size_i),
    .st_addr_i     (d_addr_i[1:0]),
    .st_wdata_i    (d_wdata_i),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .st_err_o      (st_err),
    .ld_size_i     (size_q),
    .ld_unsigned_i (unsigned_q),
    .ld_addr_i     (addr_q),
    .ld_rdata_i    (mem_rdata_i),
    .ld_data_o     (ld_data)
  );

  always_comb begin
    d_gnt_o = d_req_i & ~(i_req_i & (streak_q == MaxStreak));
    i_gnt_o = i_req_i & ~d_gnt_o;

    streak_d = streak_q;
    if (!i_req_i || i_gnt_o) begin
      streak_d = 4'd0;
    end else if (d_gnt_o && (streak_q != MaxStreak)) begin
      streak_d = streak_q + 4'd1;
    end

    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    owner_d     = OWN_NONE;
    if (d_gnt_o) begin
      mem_addr_o  = d_addr_i;
      mem_be_o    = st_be;
      mem_wdata_o = st_wdata;
      mem_we_o    = d_we_i & ~st_err;
      owner_d     = OWN_D;
    end else if (i_gnt_o) begin
      mem_addr_o = i_addr_i;
      owner_d    = OWN_I;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streak_q   <= 4'd0;
      owner_q    <= OWN_NONE;
      size_q     <= SZ_BYTE;
      addr_q     <= 2'b00;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      owner_q    <= owner_d;
      size_q     <= d_size_i;
      addr_q     <= d_addr_i[1:0];
      unsigned_q <= d_unsigned_i;
      we_q       <= d_we_i;
      err_q      <= st_err;
    end
  end

  always_comb begin
    i_rvalid_o = (owner_q == OWN_I);
    i_rdata_o  = mem_rdata_i;
    d_rvalid_o = (owner_q == OWN_D);
    d_err_o    = d_rvalid_o & err_q;
    d_rdata_o  = (d_rvalid_o && !we_q && !err_q) ? ld_data : '0;
  end

endmodule

// File: tb/tb_blockram_arbiter.sv
// Directed bench for blockram_arbiter with a behavioural registered-output byte-enabled RAM.
module tb_blockram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i, d_we_i, d_unsigned_i;
  logic [1:0]  d_size_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i = 32'h0;

  logic [31:0] ram [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  blockram_arbiter #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .MAX_D_STREAK  (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_req_i      (i_req_i),
    .i_addr_i     (i_addr_i),
    .i_gnt_o      (i_gnt_o),
    .i_rvalid_o   (i_rvalid_o),
    .i_rdata_o    (i_rdata_o),
    .d_req_i      (d_req_i),
    .d_we_i       (d_we_i),
    .d_size_i     (d_size_i),
    .d_unsigned_i (d_unsigned_i),
    .d_addr_i     (d_addr_i),
    .d_wdata_i    (d_wdata_i),
    .d_gnt_o      (d_gnt_o),
    .d_rvalid_o   (d_rvalid_o),
    .d_rdata_o    (d_rdata_o),
    .d_err_o      (d_err_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_we_o     (mem_we_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  // Read-before-write RAM: a read in the same cycle as a write returns old contents.
  always @(posedge clk_i) begin
    mem_rdata_i <= ram[mem_addr_o[9:2]];
    if (mem_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic drive_idle();
    i_req_i = 1'b0; i_addr_i = 32'h0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_size_i = 2'd0; d_unsigned_i = 1'b0;
    d_addr_i = 32'h0; d_wdata_i = 32'h0;
  endtask

  // One D transaction starting just after a rising edge; ends just after the next one.
  task automatic d_xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic gnt, output logic [3:0] be, output logic [31:0] mwd,
                        output logic mwe, output logic rv, output logic err,
                        output logic [31:0] rd);
    d_req_i = 1'b1; d_we_i = we; d_size_i = sz; d_unsigned_i = uns;
    d_addr_i = addr; d_wdata_i = wd;
    #2;
    gnt = d_gnt_o; be = mem_be_o; mwd = mem_wdata_o; mwe = mem_we_o;
    @(posedge clk_i); #1;
    drive_idle();
    rv = d_rvalid_o; err = d_err_o; rd = d_rdata_o;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_ni = 1'b0;
    #3;
    n_tests++; if (i_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_i_rvalid got %b want 0", i_rvalid_o); end
    n_tests++; if (d_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_d_rvalid got %b want 0", d_rvalid_o); end
    n_tests++; if (d_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_d_err got %b want 0", d_err_o); end
    n_tests++; if ({i_gnt_o, d_gnt_o, mem_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt_we got %b want 000", {i_gnt_o, d_gnt_o, mem_we_o}); end
    n_tests++; if (mem_be_o !== 4'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_idle_mem got be=%h addr=%h wd=%h want zeros", mem_be_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_word_store();
    logic g, mwe, rv, err; logic [3:0] be; logic [31:0] mwd, rd;
    d_xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if ({g, mwe} !== 2'b11) begin n_fail++; $display("FAIL wstore_gnt_we got %b want 11", {g, mwe}); end
    n_tests++; if (be !== 4'hF || mwd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wstore_lanes got be=%h wd=%h want F DEADBEEF", be, mwd); end
    n_tests++; if ({rv, err} !== 2'b10 || rd !== 32'h0) begin n_fail++; $display("FAIL wstore_resp got rv=%b err=%b rd=%h want 1 0 0", rv, err, rd); end
    d_xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h80011234, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if ({g, mwe, rv} !== 3'b111) begin n_fail++; $display("FAIL wstore2 got %b want 111", {g, mwe, rv}); end
  endtask

  task automatic test_fetch();
    logic g; logic [31:0] a;
    i_req_i = 1'b1; i_addr_i = 32'h10;
    #2;
    g = i_gnt_o; a = mem_addr_o;
    n_tests++; if ({g, d_gnt_o, mem_we_o} !== 3'b100) begin n_fail++; $display("FAIL fetch_gnt got %b want 100", {g, d_gnt_o, mem_we_o}); end
    n_tests++; if (a !== 32'h10) begin n_fail++; $display("FAIL fetch_addr got %h want 10", a); end
    @(posedge clk_i); #1;
    drive_idle();
    n_tests++; if ({i_rvalid_o, d_rvalid_o} !== 2'b10) begin n_fail++; $display("FAIL fetch_rvalid got %b want 10", {i_rvalid_o, d_rvalid_o}); end
    n_tests++; if (i_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata got %h want DEADBEEF", i_rdata_o); end
  endtask

  task automatic test_byte();
    logic g, mwe, rv, err; logic [3:0] be; logic [31:0] mwd, rd;
    d_xact(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (be !== 4'b1000 || mwd !== 32'hABABABAB || mwe !== 1'b1) begin
      n_fail++; $display("FAIL bstore got be=%b wd=%h we=%b want 1000 ABABABAB 1", be, mwd, mwe);
    end
    d_xact(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (mwe !== 1'b0) begin n_fail++; $display("FAIL bload_we got %b want 0", mwe); end
    n_tests++; if (rv !== 1'b1 || rd !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL bload_signed got rv=%b rd=%h want 1 FFFFFFAB", rv, rd); end
    d_xact(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (rd !== 32'h000000AB) begin n_fail++; $display("FAIL bload_unsigned got %h want 000000AB", rd); end
    d_xact(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (rd !== 32'h000000BE) begin n_fail++; $display("FAIL bload_lane1 got %h want 000000BE", rd); end
  endtask

  task automatic test_half();
    logic g, mwe, rv, err; logic [3:0] be; logic [31:0] mwd, rd;
    d_xact(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (rd !== 32'hFFFF8001 || err !== 1'b0) begin n_fail++; $display("FAIL hload_signed got rd=%h err=%b want FFFF8001 0", rd, err); end
    d_xact(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (rd !== 32'h00001234) begin n_fail++; $display("FAIL hload_unsigned got %h want 00001234", rd); end
    d_xact(1'b1, 2'd1, 1'b0, 32'h26, 32'h0000CAFE, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (be !== 4'b1100 || mwd !== 32'hCAFECAFE) begin n_fail++; $display("FAIL hstore got be=%b wd=%h want 1100 CAFECAFE", be, mwd); end
    d_xact(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000FFFF, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if ({g, mwe, be} !== 6'b100000) begin n_fail++; $display("FAIL herr_drive got gnt=%b we=%b be=%b want 1 0 0000", g, mwe, be); end
    n_tests++; if ({rv, err} !== 2'b11 || rd !== 32'h0) begin n_fail++; $display("FAIL herr_resp got rv=%b err=%b rd=%h want 1 1 0", rv, err, rd); end
    d_xact(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if ({rv, err} !== 2'b11 || rd !== 32'h0) begin n_fail++; $display("FAIL size3_err got rv=%b err=%b rd=%h want 1 1 0", rv, err, rd); end
    d_xact(1'b1, 2'd2, 1'b0, 32'h22, 32'h12345678, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if ({mwe, err} !== 2'b01 || be !== 4'h0) begin n_fail++; $display("FAIL werr got we=%b err=%b be=%b want 0 1 0000", mwe, err, be); end
    d_xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (rd !== 32'h80011234) begin n_fail++; $display("FAIL werr_nowrite got %h want 80011234", rd); end
  endtask

  task automatic test_back_to_back();
    logic g, mwe, rv, err; logic [3:0] be; logic [31:0] mwd, rd;
    d_xact(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, g, be, mwd, mwe, rv, err, rd);
    d_xact(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (g !== 1'b1 || rd !== 32'h11223344) begin n_fail++; $display("FAIL b2b_load got gnt=%b rd=%h want 1 11223344", g, rd); end
  endtask

  task automatic test_streak();
    logic exp_d;
    i_req_i = 1'b1; i_addr_i = 32'h10;
    d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd2; d_unsigned_i = 1'b0; d_addr_i = 32'h20;
    for (int c = 0; c < 10; c++) begin
      exp_d = ((c % 5) != 4);
      #2;
      n_tests++; if ({d_gnt_o, i_gnt_o} !== {exp_d, ~exp_d}) begin
        n_fail++; $display("FAIL streak_gnt cycle %0d got d=%b i=%b want d=%b i=%b", c, d_gnt_o, i_gnt_o, exp_d, ~exp_d);
      end
      @(posedge clk_i); #1;
      n_tests++; if ({d_rvalid_o, i_rvalid_o} !== {exp_d, ~exp_d}) begin
        n_fail++; $display("FAIL streak_rvalid cycle %0d got d=%b i=%b want d=%b i=%b", c, d_rvalid_o, i_rvalid_o, exp_d, ~exp_d);
      end
      n_tests++; if (exp_d ? (d_rdata_o !== 32'h80011234) : (i_rdata_o !== 32'hABADBEEF)) begin
        n_fail++; $display("FAIL streak_rdata cycle %0d got d=%h i=%h want d=80011234 or i=ABADBEEF", c, d_rdata_o, i_rdata_o);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_midop();
    logic g, mwe, rv, err; logic [3:0] be; logic [31:0] mwd, rd;
    d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd2; d_addr_i = 32'h20;
    #2;
    n_tests++; if (d_gnt_o !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got %b want 1", d_gnt_o); end
    @(negedge clk_i); rst_ni = 1'b0;
    #1; drive_idle();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i); #1;
      n_tests++; if ({d_rvalid_o, i_rvalid_o, d_err_o} !== 3'b000 || d_rdata_o !== 32'h0) begin
        n_fail++; $display("FAIL midrst_hold got rv=%b%b err=%b rd=%h want 000 0", d_rvalid_o, i_rvalid_o, d_err_o, d_rdata_o);
      end
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_tests++; if (d_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_after got %b want 0", d_rvalid_o); end
    d_xact(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, g, be, mwd, mwe, rv, err, rd);
    n_tests++; if (rv !== 1'b1 || rd !== 32'h11223344) begin n_fail++; $display("FAIL midrst_recover got rv=%b rd=%h want 1 11223344", rv, rd); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_fetch();
    test_byte();
    test_half();
    test_back_to_back();
    test_streak();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/blockram_arbiter.md
Name: blockram_arbiter

Overview:
- Shares one single-port, byte-enabled program/data blockram between the instruction-fetch port (I) and the load/store port (D).
- Arbitrates each cycle between I and D.
- Converts D sub-word stores into byte enables plus lane-shifted write data.
- Aligns and extends read data returned one cycle later by the RAM's registered output.
- Sits between the core and the blockram instance.

Parameters:
- ADDRESS_WIDTH, 32, byte address width of both ports and the RAM.
- DATA_WIDTH, 32, word width; the block supports 32 only.
- MAX_D_STREAK, 4, maximum consecutive D grants while i_req is pending; must be 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  ADDRESS_WIDTH  fetch byte address; bits [1:0] ignored
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_WIDTH  fetched word
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- d_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- d_addr  in  ADDRESS_WIDTH  byte address
- d_wdata  in  DATA_WIDTH  store data, right-justified
- d_gnt  out  1  D accepted this cycle (combinational)
- d_rvalid  out  1  D response valid (loads and stores)
- d_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- d_err  out  1  misaligned or illegal-size access; qualified by d_rvalid
- mem_addr  out  ADDRESS_WIDTH  RAM address (word index = [31:2])
- mem_be  out  4  RAM byte enables
- mem_wdata  out  DATA_WIDTH  RAM write data, lane-positioned
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_WIDTH  RAM registered read data, valid one cycle after address

Behaviour:
- Reset:
  - i_rvalid, d_rvalid and d_err are 0.
  - Response-owner register is NONE; streak counter is 0.
  - Combinational outputs follow the idle rule below.
- Arbitration (combinational, per cycle):
  - D wins if d_req and not (i_req and streak == MAX_D_STREAK).
  - Otherwise I wins if i_req.
  - At most one gnt is high per cycle.
  - Requester must hold req and all request fields stable until gnt.
- Streak counter (4 bits):
  - Increments on a D grant while i_req is high.
  - Clears on an I grant or when i_req is low.
  - Saturates at MAX_D_STREAK.
- Drive on an I grant: mem_addr = i_addr, mem_we = 0, mem_be = 0.
- Drive on a D grant:
  - mem_addr = d_addr.
  - Byte store: mem_be = 1 << addr[1:0]; mem_wdata = d_wdata[7:0] replicated to all lanes.
  - Half store: mem_be = 3 << addr[1:0]; mem_wdata = d_wdata[15:0] replicated to both halves.
  - Word store: mem_be = 4'hF; mem_wdata = d_wdata.
  - mem_we = d_we and not error.
- Error: d_size == 3, half with addr[0] = 1, or word with addr[1:0] != 0.
  - Access is granted, but mem_we = 0 and mem_be = 0.
  - Response next cycle: d_rvalid = 1, d_err = 1, d_rdata = 0.
- Idle (no grant): mem_addr = 0, mem_we = 0, mem_be = 0, mem_wdata = 0.
- Response pipeline:
  - Latency is exactly 1 cycle after gnt.
  - Registered owner (I/D/NONE), d_size, d_unsigned, addr[1:0], we and err.
  - Next cycle, the owner's rvalid = 1.
  - I: i_rdata = mem_rdata.
  - D load: select lane mem_rdata >> (8*addr[1:0]), then extend by size and unsigned.
  - D store: d_rdata = 0.
- Throughput: back-to-back grants each cycle are legal; no stall.
- Read-during-write: RAM returns old contents, passed through unmodified (stores return 0 anyway).
- Reset mid-operation: an in-flight response is dropped and no rvalid is produced.

Decomposition:
- Shared package blockram_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - owner enum OWN_NONE/OWN_I/OWN_D.
  - constant BYTES = 4.
- One sub-module lsu_align:
  - combinational store lane/be generation.
  - combinational load extract/extend.
  - combinational misalignment detect.
- Arbiter, streak counter and response register stay in the top.

Test Plan:
- Reset, then i_req only with i_addr = 0x10 and RAM word[4] = 0xDEADBEEF
  -> i_gnt in the same cycle; next cycle i_rvalid = 1, i_rdata = 0xDEADBEEF; d_rvalid = 0.
- Byte store d_addr = 0x13, d_wdata = 0xAB
  -> mem_be = 4'b1000, mem_wdata = 0xABABABAB.
  - Then a signed byte load at 0x13 -> d_rdata = 0xFFFFFFAB.
  - Then an unsigned byte load at 0x13 -> d_rdata = 0x000000AB.
- Half load at addr 0x22 with word = 0x8001_1234
  -> signed d_rdata = 0xFFFF8001.
  - Half access at addr 0x21 -> d_rvalid = 1, d_err = 1, mem_we = 0, d_rdata = 0.
- i_req and d_req held high continuously with MAX_D_STREAK = 4
  -> grant sequence D, D, D, D, I, repeating.
  - Never two gnts in one cycle; every grant yields exactly one rvalid one cycle later.
- Back-to-back word store 0x11223344 to 0x40, then a load of 0x40 in the next cycle
  -> load returns 0x11223344.
- Assert rst_n low the cycle after a D load grant
  -> no d_rvalid emitted; all outputs at reset values while rst_n = 0.
